clk_freq_mon: RTL
=================

CLK_FREQ_MON -- requirements
Module: clk_freq_mon

Interface
REQ-001 SHALL have parameter WINDOW, default 50000, wb_clk_o cycles per measurement window (1 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 20, width of monitored-clock counter and result.
REQ-003 SHALL have parameter LOW_LIMIT, default 260000, minimum acceptable count per window.
REQ-004 SHALL have parameter HIGH_LIMIT, default 273000, maximum acceptable count per window.
REQ-005 SHALL have port wb_clk_o  input  1  measurement/register clock.
REQ-006 SHALL have port async_rst_o  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port mon_clk_i  input  1  clock under measurement, asynchronous to wb_clk_o.
REQ-008 SHALL have port lock_i  input  1  PLL/DCM locked indication, asynchronous.
REQ-009 SHALL have port en_i  input  1  measurement enable, wb_clk_o domain.
REQ-010 SHALL have port clr_i  input  1  one-cycle clear of lock_lost_o, wb_clk_o domain.
REQ-011 SHALL have port freq_cnt_o  output  CNT_W  mon_clk_i edges counted in last complete window.
REQ-012 SHALL have port freq_valid_o  output  1  one-cycle pulse when freq_cnt_o updates.
REQ-013 SHALL have port out_of_range_o  output  1  last result < LOW_LIMIT or > HIGH_LIMIT.
REQ-014 SHALL have port lock_lost_o  output  1  sticky: synchronized lock_i fell since last clear.

Function
REQ-015 SHALL run a free-running CNT_W-bit binary counter on mon_clk_i, wrapping modulo 2^CNT_W, published as registered Gray code.
REQ-016 SHALL synchronize the Gray count into wb_clk_o with two flops and convert to binary there.
REQ-017 SHALL implement FSM states IDLE, PRIME, MEASURE; IDLE->PRIME when en_i=1; PRIME samples count S0, ->MEASURE; MEASURE counts WINDOW wb_clk_o cycles, then samples S1.
REQ-018 SHALL at each MEASURE sample compute D=(S1-S0) mod 2^CNT_W, set S0<=S1, restart the window with no gap (back-to-back windows).
REQ-019 SHALL register D to freq_cnt_o and pulse freq_valid_o exactly one cycle after the sample cycle; first pulse WINDOW+1 cycles after PRIME.
REQ-020 SHALL update out_of_range_o in the same cycle as freq_valid_o; held between updates.
REQ-021 SHALL treat a stopped mon_clk_i as D=0, giving out_of_range_o=1 when LOW_LIMIT>0.
REQ-022 SHALL on en_i=0 in any state go to IDLE next cycle, discard partial window, no pulse; freq_cnt_o/out_of_range_o hold.
REQ-023 SHALL synchronize lock_i with two flops; falling edge of synced value sets lock_lost_o; clr_i clears; set wins over simultaneous clr_i.
REQ-024 SHALL require WINDOW * f_mon / f_wb < 2^CNT_W; larger counts alias (not detected).

Reset
REQ-025 SHALL assert async_rst_o asynchronously into both domains; mon_clk_i-domain deassertion synchronized by two flops.
REQ-026 SHALL reset: FSM=IDLE, freq_cnt_o=0, freq_valid_o=0, out_of_range_o=0, lock_lost_o=0, counters/samples=0, synced lock=0 (no lock_lost set on first rise).
REQ-027 SHALL on reset mid-window drop all state; measurement restarts via PRIME after reset release with en_i=1.

Structure
REQ-028 SHALL place FSM state encoding and default WINDOW/limit constants in shared package clkgen_pkg.
REQ-029 SHALL implement counter, Gray encode, reset sync and two-flop sync in sub-module gray_cnt_sync.

Verification
REQ-030 SHALL cover: WINDOW=100, mon_clk_i = 2x wb_clk_o, en_i=1 -> freq_valid_o every 100 cycles, freq_cnt_o in 199..201.
REQ-031 SHALL cover: CNT_W=8, WINDOW=100, mon 2x -> counter wraps each window, freq_cnt_o still 199..201.
REQ-032 SHALL cover: mon_clk_i stopped, LOW_LIMIT=150 -> freq_cnt_o=0, out_of_range_o=1 at next pulse.
REQ-033 SHALL cover: lock_i 1->0 with clr_i pulsed same cycle synced edge arrives -> lock_lost_o=1; later clr_i alone -> 0.
REQ-034 SHALL cover: en_i dropped at cycle 50 of window -> no pulse; re-enable -> first pulse 101 cycles after PRIME.
REQ-035 SHALL cover: async_rst_o mid-window -> all outputs 0 immediately; no pulse until WINDOW+1 cycles after PRIME.

Source files
------------

// File: rtl/clkgen_pkg.sv
// Shared FSM encoding, default window/limit constants and range helper
// for the clock frequency monitor.
package clkgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRIME   = 2'd1,
    ST_MEASURE = 2'd2
  } fsm_state_t;

  localparam int unsigned DEF_WINDOW     = 50000;   // 1 ms at 50 MHz
  localparam int unsigned DEF_CNT_W      = 20;
  localparam int unsigned DEF_LOW_LIMIT  = 260000;
  localparam int unsigned DEF_HIGH_LIMIT = 273000;

  function automatic logic out_of_range(input logic [31:0] d,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    return (d < lo) || (d > hi);
  endfunction

endpackage

// File: rtl/gray_cnt_sync.sv
// Free-running counter on the monitored clock, published as Gray code and
// brought into the wb_clk_o domain through two flops, then decoded to binary.
module gray_cnt_sync
  import clkgen_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             mon_clk_i,
  input  logic             wb_clk_o,
  input  logic             async_rst_o,
  output logic [CNT_W-1:0] cnt_bin
);

  logic [1:0]       mon_rst_sync_reg;
  logic             mon_rst;
  logic [CNT_W-1:0] bin_reg;
  logic [CNT_W-1:0] bin_next;
  logic [CNT_W-1:0] gray_reg;
  logic [CNT_W-1:0] gray_meta_reg;
  logic [CNT_W-1:0] gray_sync_reg;

  // Reset asserts immediately in the monitored domain; release follows two mon edges.
  always_ff @(posedge mon_clk_i or posedge async_rst_o) begin
    if (async_rst_o) begin
      mon_rst_sync_reg <= 2'b11;
    end else begin
      mon_rst_sync_reg <= {mon_rst_sync_reg[0], 1'b0};
    end
  end

  assign mon_rst  = mon_rst_sync_reg[1];
  assign bin_next = bin_reg + 1'b1;

  always_ff @(posedge mon_clk_i or posedge mon_rst) begin
    if (mon_rst) begin
      bin_reg  <= '0;
      gray_reg <= '0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= bin_next ^ (bin_next >> 1);
    end
  end

  always_ff @(posedge wb_clk_o or posedge async_rst_o) begin
    if (async_rst_o) begin
      gray_meta_reg <= '0;
      gray_sync_reg <= '0;
    end else begin
      gray_meta_reg <= gray_reg;
      gray_sync_reg <= gray_meta_reg;
    end
  end

  // Each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < CNT_W; gi++) begin : g_gray2bin
      assign cnt_bin[gi] = ^gray_sync_reg[CNT_W-1:gi];
    end
  endgenerate

endmodule

// File: rtl/clk_freq_mon.sv
// Measures mon_clk_i edges per WINDOW wb_clk_o cycles, flags out-of-range
// results and latches loss of PLL lock.
module clk_freq_mon
  import clkgen_pkg::*;
#(
  parameter int unsigned WINDOW     = DEF_WINDOW,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned LOW_LIMIT  = DEF_LOW_LIMIT,
  parameter int unsigned HIGH_LIMIT = DEF_HIGH_LIMIT
) (
  input  logic             wb_clk_o,
  input  logic             async_rst_o,
  input  logic             mon_clk_i,
  input  logic             lock_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] freq_cnt_o,
  output logic             freq_valid_o,
  output logic             out_of_range_o,
  output logic             lock_lost_o
);

  localparam int unsigned   WIN_W    = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  fsm_state_t       state_reg;
  fsm_state_t       state_next;
  logic             prime_smp;
  logic             meas_smp;
  logic [WIN_W-1:0] win_cnt_reg;
  logic [CNT_W-1:0] cnt_bin;
  logic [CNT_W-1:0] s0_reg;
  logic [CNT_W-1:0] d_next;
  logic [CNT_W-1:0] freq_cnt_reg;
  logic             freq_valid_reg;
  logic             oor_reg;
  logic             lock_meta_reg;
  logic             lock_sync_reg;
  logic             lock_prev_reg;
  logic             lock_lost_reg;
  logic             lock_fall;

  gray_cnt_sync #(
    .CNT_W (CNT_W)
  ) u_gray_cnt_sync (
    .mon_clk_i   (mon_clk_i),
    .wb_clk_o    (wb_clk_o),
    .async_rst_o (async_rst_o),
    .cnt_bin     (cnt_bin)
  );

  always_ff @(posedge wb_clk_o or posedge async_rst_o) begin
    if (async_rst_o) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!en_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:    state_next = ST_PRIME;
        ST_PRIME:   state_next = ST_MEASURE;
        ST_MEASURE: state_next = ST_MEASURE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    prime_smp = 1'b0;
    meas_smp  = 1'b0;
    case (state_reg)
      ST_PRIME:   prime_smp = en_i;
      ST_MEASURE: meas_smp  = en_i && (win_cnt_reg == WIN_LAST);
      default:    ;
    endcase
  end

  // Modular subtraction absorbs counter wrap between the two samples.
  assign d_next = cnt_bin - s0_reg;

  always_ff @(posedge wb_clk_o or posedge async_rst_o) begin
    if (async_rst_o) begin
      win_cnt_reg    <= '0;
      s0_reg         <= '0;
      freq_cnt_reg   <= '0;
      freq_valid_reg <= 1'b0;
      oor_reg        <= 1'b0;
    end else begin
      freq_valid_reg <= meas_smp;
      if (state_reg != ST_MEASURE || meas_smp) begin
        win_cnt_reg <= '0;
      end else begin
        win_cnt_reg <= win_cnt_reg + 1'b1;
      end
      if (prime_smp || meas_smp) begin
        s0_reg <= cnt_bin;
      end
      if (meas_smp) begin
        freq_cnt_reg <= d_next;
        oor_reg      <= out_of_range(32'(d_next), LOW_LIMIT, HIGH_LIMIT);
      end
    end
  end

  assign lock_fall = lock_prev_reg && !lock_sync_reg;

  // A fresh lock-loss event takes priority over a coincident clear.
  always_ff @(posedge wb_clk_o or posedge async_rst_o) begin
    if (async_rst_o) begin
      lock_meta_reg <= 1'b0;
      lock_sync_reg <= 1'b0;
      lock_prev_reg <= 1'b0;
      lock_lost_reg <= 1'b0;
    end else begin
      lock_meta_reg <= lock_i;
      lock_sync_reg <= lock_meta_reg;
      lock_prev_reg <= lock_sync_reg;
      if (lock_fall) begin
        lock_lost_reg <= 1'b1;
      end else if (clr_i) begin
        lock_lost_reg <= 1'b0;
      end
    end
  end

  assign freq_cnt_o     = freq_cnt_reg;
  assign freq_valid_o   = freq_valid_reg;
  assign out_of_range_o = oor_reg;
  assign lock_lost_o    = lock_lost_reg;

endmodule
